// File: rtl/pc_sequencer.sv
// Program-flow sequencer: registered PC with start/run/done control, stall,
// PC-relative branch/call, a bounded return-address stack and sticky stack errors.
module pc_sequencer #(
    parameter int PC_W        = 12,
    parameter int OFF_W       = 8,
    parameter int STACK_DEPTH = 4,
    parameter int START_ADDR  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic             branch_en,
    input  logic             call,
    input  logic             ret,
    input  logic             halt,
    input  logic [OFF_W-1:0] branch_off,
    output logic [PC_W-1:0]  pc,
    output logic             done,
    output logic             running,
    output logic             stack_err
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int EXT_W = PC_W - OFF_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);
    localparam logic [SP_W-1:0] SP_FULL  = SP_W'(STACK_DEPTH);

    logic [1:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [SP_W-1:0] sp_q, sp_d;
    logic            stack_err_q, stack_err_d;
    logic            done_q, done_d;
    logic            running_q, running_d;

    // Return-address storage carries no reset; only sp marks valid entries.
    logic [PC_W-1:0] stack_q [STACK_DEPTH];

    logic [PC_W-1:0]  off_ext;
    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  pc_jump;
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] pop_idx;
    logic             push_en;

    generate
        if (EXT_W > 0) begin : g_sext
            assign off_ext = {{EXT_W{branch_off[OFF_W-1]}}, branch_off};
        end else begin : g_nosext
            assign off_ext = branch_off;
        end
    endgenerate

    assign pc_inc   = pc_q + PC_W'(1);
    assign pc_jump  = pc_inc + off_ext;
    assign push_idx = IDX_W'(sp_q);
    assign pop_idx  = IDX_W'(sp_q - SP_W'(1));

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        sp_d        = sp_q;
        stack_err_d = stack_err_q;
        push_en     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (!start) state_d = ST_RUN;
            end
            ST_RUN: begin
                // One action per cycle, highest priority first.
                if (start) begin
                    state_d = ST_LOAD;
                end else if (halt) begin
                    state_d = ST_DONE;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (ret) begin
                    if (sp_q != '0) begin
                        pc_d = stack_q[pop_idx];
                        sp_d = sp_q - SP_W'(1);
                    end else begin
                        stack_err_d = 1'b1;
                        pc_d        = pc_inc;
                    end
                end else if (call) begin
                    if (sp_q < SP_FULL) begin
                        push_en = 1'b1;
                        sp_d    = sp_q + SP_W'(1);
                    end else begin
                        stack_err_d = 1'b1;
                    end
                    pc_d = pc_jump;
                end else if (branch_en) begin
                    pc_d = pc_jump;
                end else begin
                    pc_d = pc_inc;
                end
            end
            default: begin
                if (start) state_d = ST_LOAD;
            end
        endcase

        // Entering or holding LOAD re-arms the run from a clean state.
        if (state_d == ST_LOAD) begin
            pc_d        = START_PC;
            sp_d        = '0;
            stack_err_d = 1'b0;
        end

        done_d    = (state_d == ST_DONE);
        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= START_PC;
            sp_q        <= '0;
            stack_err_q <= 1'b0;
            done_q      <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            sp_q        <= sp_d;
            stack_err_q <= stack_err_d;
            done_q      <= done_d;
            running_q   <= running_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) stack_q[push_idx] <= pc_inc;
    end

    assign pc        = pc_q;
    assign done      = done_q;
    assign running   = running_q;
    assign stack_err = stack_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with default parameters (PC_W=12, OFF_W=8,
// STACK_DEPTH=4, START_ADDR=0); expected values are hand-computed.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stall;
    logic        branch_en;
    logic        call;
    logic        ret;
    logic        halt;
    logic [7:0]  branch_off;
    logic [11:0] pc;
    logic        done;
    logic        running;
    logic        stack_err;

    int checks;
    int failures;

    pc_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stall      (stall),
        .branch_en  (branch_en),
        .call       (call),
        .ret        (ret),
        .halt       (halt),
        .branch_off (branch_off),
        .pc         (pc),
        .done       (done),
        .running    (running),
        .stack_err  (stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_flow();
        stall = 0; branch_en = 0; call = 0; ret = 0; halt = 0; branch_off = 8'h00;
    endtask

    // One-cycle start pulse, then one edge into RUN with pc at START_ADDR.
    task automatic restart();
        clear_flow();
        start = 1;
        cyc();
        start = 0;
        cyc();
    endtask

    task automatic test_reset();
        reset = 1; start = 0; clear_flow();
        cyc();
        cyc();
        checks++;
        if (pc !== 12'h000) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 12'h000); end
        checks++;
        if ({done, running, stack_err} !== 3'b000) begin
            failures++; $display("FAIL reset_flags got=%b exp=%b", {done, running, stack_err}, 3'b000);
        end
        reset = 0;
        cyc();
        checks++;
        if (running !== 1'b0) begin failures++; $display("FAIL idle_no_start got=%b exp=0", running); end
    endtask

    task automatic test_defaults();
        start = 1;
        cyc();
        checks++;
        if ({running, pc} !== {1'b0, 12'h000}) begin
            failures++; $display("FAIL load_state got=%b/%h exp=0/000", running, pc);
        end
        start = 0;
        cyc();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({running, pc} !== {1'b1, 12'(i)}) begin
                failures++; $display("FAIL seq_pc%0d got=%b/%h exp=1/%h", i, running, pc, 12'(i));
            end
            cyc();
        end
    endtask

    task automatic test_start_hold();
        start = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if ({running, done, pc} !== {2'b00, 12'h000}) begin
                failures++; $display("FAIL start_hold%0d got=%b%b/%h exp=00/000", i, running, done, pc);
            end
        end
        start = 0;
        cyc();
        checks++;
        if ({running, pc} !== {1'b1, 12'h000}) begin
            failures++; $display("FAIL start_release got=%b/%h exp=1/000", running, pc);
        end
    endtask

    task automatic test_branch_wrap();
        restart();
        cyc();
        cyc();
        checks++;
        if (pc !== 12'h002) begin failures++; $display("FAIL pre_branch_pc got=%h exp=002", pc); end
        branch_en = 1; branch_off = 8'hF8;
        cyc();
        clear_flow();
        checks++;
        if (pc !== 12'hFFB) begin failures++; $display("FAIL branch_neg got=%h exp=ffb", pc); end
        for (int i = 0; i < 4; i++) cyc();
        checks++;
        if (pc !== 12'hFFF) begin failures++; $display("FAIL pc_top got=%h exp=fff", pc); end
        cyc();
        checks++;
        if (pc !== 12'h000) begin failures++; $display("FAIL pc_wrap got=%h exp=000", pc); end
    endtask

    task automatic test_call_ret();
        restart();
        branch_en = 1; branch_off = 8'h0F;
        cyc();
        clear_flow();
        checks++;
        if (pc !== 12'h010) begin failures++; $display("FAIL branch_pos got=%h exp=010", pc); end
        call = 1; branch_off = 8'h20;
        cyc();
        checks++;
        if (pc !== 12'h031) begin failures++; $display("FAIL call1 got=%h exp=031", pc); end
        branch_off = 8'h05;
        cyc();
        checks++;
        if (pc !== 12'h037) begin failures++; $display("FAIL call2 got=%h exp=037", pc); end
        clear_flow();
        ret = 1;
        cyc();
        checks++;
        if (pc !== 12'h032) begin failures++; $display("FAIL ret1 got=%h exp=032", pc); end
        cyc();
        checks++;
        if (pc !== 12'h011) begin failures++; $display("FAIL ret2 got=%h exp=011", pc); end
        checks++;
        if (stack_err !== 1'b0) begin failures++; $display("FAIL nest_err got=%b exp=0", stack_err); end
        clear_flow();
    endtask

    task automatic test_overflow_underflow();
        logic [11:0] exp_pc;
        restart();
        call = 1; branch_off = 8'h02;
        exp_pc = 12'h000;
        for (int i = 0; i < 5; i++) begin
            cyc();
            exp_pc = exp_pc + 12'h003;
            checks++;
            if ({stack_err, pc} !== {(i == 4), exp_pc}) begin
                failures++; $display("FAIL call_depth%0d got=%b/%h exp=%b/%h", i, stack_err, pc, (i == 4), exp_pc);
            end
        end
        clear_flow();
        cyc();
        ret = 1;
        cyc();
        clear_flow();
        checks++;
        if ({stack_err, pc} !== {1'b1, 12'h00A}) begin
            failures++; $display("FAIL ovf_top_intact got=%b/%h exp=1/00a", stack_err, pc);
        end
        start = 1;
        cyc();
        checks++;
        if (stack_err !== 1'b0) begin failures++; $display("FAIL err_clear_ovf got=%b exp=0", stack_err); end
        start = 0;
        cyc();
        ret = 1;
        cyc();
        clear_flow();
        checks++;
        if ({stack_err, pc} !== {1'b1, 12'h001}) begin
            failures++; $display("FAIL underflow got=%b/%h exp=1/001", stack_err, pc);
        end
        start = 1;
        cyc();
        start = 0;
        checks++;
        if (stack_err !== 1'b0) begin failures++; $display("FAIL err_clear_unf got=%b exp=0", stack_err); end
    endtask

    task automatic test_priority_halt();
        restart();
        branch_en = 1; branch_off = 8'h3F;
        cyc();
        clear_flow();
        // stall outranks ret and branch: pc holds and no underflow is flagged
        stall = 1; ret = 1; branch_en = 1; branch_off = 8'h10;
        cyc();
        clear_flow();
        checks++;
        if ({stack_err, pc} !== {1'b0, 12'h040}) begin
            failures++; $display("FAIL stall_hold got=%b/%h exp=0/040", stack_err, pc);
        end
        halt = 1; stall = 1; branch_en = 1; branch_off = 8'h05;
        cyc();
        clear_flow();
        checks++;
        if ({done, running, pc} !== {2'b10, 12'h040}) begin
            failures++; $display("FAIL halt got=%b%b/%h exp=10/040", done, running, pc);
        end
        branch_en = 1; call = 1; ret = 1; branch_off = 8'h22;
        cyc();
        cyc();
        clear_flow();
        checks++;
        if ({done, stack_err, pc} !== {2'b10, 12'h040}) begin
            failures++; $display("FAIL done_ignores got=%b%b/%h exp=10/040", done, stack_err, pc);
        end
        start = 1;
        cyc();
        checks++;
        if ({done, running, pc} !== {2'b00, 12'h000}) begin
            failures++; $display("FAIL done_restart got=%b%b/%h exp=00/000", done, running, pc);
        end
        start = 0;
        cyc();
        cyc();
        cyc();
        start = 1; halt = 1;
        cyc();
        clear_flow();
        checks++;
        if ({done, running, pc} !== {2'b00, 12'h000}) begin
            failures++; $display("FAIL start_over_halt got=%b%b/%h exp=00/000", done, running, pc);
        end
        start = 0;
        cyc();
    endtask

    task automatic test_async_reset();
        restart();
        call = 1; branch_off = 8'h10;
        cyc();
        cyc();
        clear_flow();
        cyc();
        checks++;
        if (pc !== 12'h023) begin failures++; $display("FAIL pre_reset_pc got=%h exp=023", pc); end
        #2;
        reset = 1;
        #1;
        checks++;
        if ({done, running, pc} !== {2'b00, 12'h000}) begin
            failures++; $display("FAIL async_reset got=%b%b/%h exp=00/000", done, running, pc);
        end
        #1;
        reset = 0;
        cyc();
        checks++;
        if (running !== 1'b0) begin failures++; $display("FAIL post_reset_idle got=%b exp=0", running); end
        restart();
        ret = 1;
        cyc();
        clear_flow();
        checks++;
        if ({stack_err, pc} !== {1'b1, 12'h001}) begin
            failures++; $display("FAIL ret_after_reset got=%b/%h exp=1/001", stack_err, pc);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_defaults();
        test_start_hold();
        test_branch_wrap();
        test_call_ret();
        test_overflow_underflow();
        test_priority_halt();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-flow sequencer for the next-generation core. It replaces the fixed 12-bit PC register, PC+1 adder pair and branch-offset adder with one registered block. The block adds a start/run/done state machine, a stall input, a bounded hardware call/return stack and sticky stack-error reporting. It drives the instruction-memory address and the top-level `done`, and takes per-cycle flow requests from the controller.

## Interface
Parameters:
- `PC_W`, 12, width of the PC and of the instruction address.
- `OFF_W`, 8, width of the signed branch/call offset; must be ≤ `PC_W`.
- `STACK_DEPTH`, 4, number of return-address entries; must be ≥ 1.
- `START_ADDR`, 0, PC value loaded on reset and on start.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; forces all state to reset values immediately.
- `start` in 1: level request to (re)load and arm a program run.
- `stall` in 1: hold the PC this cycle (RUN only).
- `branch_en` in 1: take a PC-relative branch this cycle.
- `call` in 1: PC-relative jump that also pushes the return address.
- `ret` in 1: pop the return address into the PC.
- `halt` in 1: end of program.
- `branch_off` in `OFF_W`: two's-complement offset; it is sign-extended to `PC_W`.
- `pc` out `PC_W`: registered current PC (instruction address).
- `done` out 1: registered; high in DONE.
- `running` out 1: registered; high in RUN.
- `stack_err` out 1: registered, sticky; set on overflow or underflow.

## Operation
States: IDLE, LOAD, RUN, DONE. After reset the state is IDLE, `pc`=`START_ADDR`, the stack pointer `sp`=0, and `done`=`running`=`stack_err`=0.

State transitions:
- IDLE: if `start`=1, go to LOAD; otherwise hold.
- LOAD: set `pc`=`START_ADDR`, `sp`=0, `stack_err`=0. Stay in LOAD while `start`=1. When `start`=0, go to RUN. The first fetch in RUN is at `START_ADDR`.
- RUN: exactly one action per cycle, in this priority order:
  1. `start`: go to LOAD.
  2. `halt`: go to DONE; `pc` holds.
  3. `stall`: `pc` and `sp` hold.
  4. `ret`:
     - If `sp`>0: `pc`=stack[`sp`-1], then `sp`-1.
     - If `sp`=0 (underflow): `stack_err`=1 and `pc`=`pc`+1.
  5. `call`:
     - If `sp`<`STACK_DEPTH`: stack[`sp`]=`pc`+1, then `sp`+1, and `pc`=`pc`+1+sext(`branch_off`).
     - If `sp`=`STACK_DEPTH` (overflow): `stack_err`=1, no push, and the jump is still taken.
  6. `branch_en`: `pc`=`pc`+1+sext(`branch_off`).
  7. Otherwise: `pc`=`pc`+1.
- DONE: `pc`, `sp` and `stack_err` hold. `start`=1 goes to LOAD. All other inputs are ignored.

Arithmetic and width rules:
- All PC arithmetic is modulo 2^`PC_W`; wrap-around is silent in both directions.
- `sp` is ⌈log2(`STACK_DEPTH`+1)⌉ bits wide.
- Stack entries are `PC_W` bits. They are not cleared by reset; only `sp` is reset.

Flow inputs are ignored in IDLE, LOAD and DONE.

## Timing
- Every output is a flop: a decision taken at edge N is visible after edge N.
- `pc` is a zero-latency fetch address. Flow inputs sampled at edge N select the `pc` shown after edge N.
- `done` rises one cycle after `halt` is sampled in RUN. It stays high until `start` is sampled, and falls on the edge that enters LOAD.
- `running` is high exactly in RUN.
- Reset mid-run takes effect immediately and asynchronously, and is not masked by any input. The post-reset state is IDLE, with `done`=0 and stack contents abandoned.
- `start` held for multiple cycles keeps the block in LOAD. RUN begins on the first edge after `start` is seen low.
- `start` high on the same edge as `halt` in RUN goes to LOAD, because start has priority.

## Test plan
- Defaults. Reset, pulse `start` for 1 cycle, then run 5 cycles with no flow inputs → `pc` sequence 0,1,2,3,4, with `running`=1 from the first RUN cycle.
- Branch wrap. `pc`=2, `branch_en`=1, `branch_off`=8'hF8 (−8) → `pc`=0xFFB. Then `pc`=0xFFF with no branch → `pc`=0x000.
- Call/ret nesting. Call at `pc`=0x010 with offset 0x20 → `pc`=0x031 and 0x011 pushed. Call at 0x031 with offset 0x05 → `pc`=0x037. Ret → `pc`=0x032; ret → `pc`=0x011; `stack_err`=0.
- Overflow and underflow. Five calls with `STACK_DEPTH`=4 → `stack_err`=1 after the fifth, and the jump is still taken. New run with a ret at `sp`=0 → `stack_err`=1 and `pc`=`pc`+1. Restart via `start` → `stack_err`=0.
- Priority and halt. `halt`, `stall` and `branch_en` asserted together at `pc`=0x040 → DONE, `pc` stays 0x040, and `done`=1 on the next cycle. Inputs in DONE do not change `pc`. `start` → `done`=0 and `pc`=0.
- Async reset. Assert `reset` mid-cycle in RUN with `sp`=2 → `pc`=0, `done`=`running`=0, state IDLE before the next edge. A following ret after restart → `stack_err`=1.
